// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed little-endian byte stream and writes 32-bit words
// into instruction memory, then releases the core PC once the checksum verifies.
module imem_boot_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              EN_PC,
   output logic              load_done,
   output logic              load_err
);

   localparam int unsigned CW    = ADDR_W + 1;
   localparam int unsigned DEPTH = 32'(1) << ADDR_W;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_HDR_LO = 3'd1;
   localparam logic [2:0] S_HDR_HI = 3'd2;
   localparam logic [2:0] S_DATA   = 3'd3;
   localparam logic [2:0] S_CSUM   = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [7:0]        n_lo_q, n_lo_d;
   logic [CW-1:0]     n_q, n_d;
   logic [CW-1:0]     word_cnt_q, word_cnt_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [23:0]       asm_q, asm_d;
   logic [7:0]        csum_q, csum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              en_pc_q, en_pc_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              accept;
   logic [15:0]       n_full;
   logic [CW-1:0]     cnt_inc;

   // rx_ready is a pure decode of the state so that no byte is taken outside the frame phases
   always_comb begin
      rx_ready = 1'b0;
      case (state_q)
         S_HDR_LO, S_HDR_HI, S_DATA, S_CSUM: rx_ready = 1'b1;
         default:                            rx_ready = 1'b0;
      endcase
   end

   assign accept  = rx_valid && rx_ready;
   assign n_full  = {rx_data, n_lo_q};
   assign cnt_inc = word_cnt_q + CW'(1);

   always_comb begin
      state_d    = state_q;
      n_lo_d     = n_lo_q;
      n_d        = n_q;
      word_cnt_d = word_cnt_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      csum_d     = csum_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      en_pc_d    = en_pc_q;
      done_d     = done_q;
      err_d      = err_q;

      // restart outranks any accept, including a 4th byte in the same cycle
      if (restart) begin
         state_d    = S_IDLE;
         n_lo_d     = 8'd0;
         n_d        = '0;
         word_cnt_d = '0;
         byte_cnt_d = 2'd0;
         asm_d      = 24'd0;
         csum_d     = 8'd0;
         en_pc_d    = 1'b0;
         done_d     = 1'b0;
         err_d      = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: state_d = S_HDR_LO;
            S_HDR_LO: begin
               if (accept) begin
                  n_lo_d  = rx_data;
                  state_d = S_HDR_HI;
               end
            end
            S_HDR_HI: begin
               if (accept) begin
                  n_d = CW'(n_full);
                  if (32'(n_full) > DEPTH) begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end else if (n_full == 16'd0) begin
                     state_d = S_CSUM;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  csum_d     = csum_q ^ rx_data;
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  asm_d      = {rx_data, asm_q[23:8]};
                  if (byte_cnt_q == 2'd3) begin
                     we_d       = 1'b1;
                     addr_d     = word_cnt_q[ADDR_W-1:0];
                     wdata_d    = {rx_data, asm_q};
                     word_cnt_d = cnt_inc;
                     if (cnt_inc == n_q) state_d = S_CSUM;
                  end
               end
            end
            S_CSUM: begin
               if (accept) begin
                  if (rx_data == csum_q) begin
                     state_d = S_DONE;
                     en_pc_d = 1'b1;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end
               end
            end
            S_DONE, S_ERR: state_d = state_q;
            default:       state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         n_lo_q     <= 8'd0;
         n_q        <= '0;
         word_cnt_q <= '0;
         byte_cnt_q <= 2'd0;
         asm_q      <= 24'd0;
         csum_q     <= 8'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         en_pc_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_lo_q     <= n_lo_d;
         n_q        <= n_d;
         word_cnt_q <= word_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         csum_q     <= csum_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         en_pc_q    <= en_pc_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign EN_PC      = en_pc_q;
   assign load_done  = done_q;
   assign load_err   = err_q;

endmodule
